i2c_mem_target: RTL and testbench

- I2C target (slave) that exposes a byte-addressed memory to an external I2C controller.
- It is the far end of the controller-side I2C memory link: the board-side responder that the CPU's I2C memory master talks to.
- The byte memory sits outside this block. The block drives a simple synchronous SRAM-style port with 1-cycle read latency.
- Transaction format:
  - Write: [START, addr+W, pointer byte, data bytes..., STOP].
  - Read: [START, addr+R, data bytes..., NACK, STOP]. Repeated START is supported.

---
 rtl/i2c_mem_target.sv | 185 ++++++++++++++++++
 tb/tb_i2c_mem_target.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_target.sv
// I2C target exposing an external byte-addressed SRAM-style memory.
// Write: START, addr+W, pointer, data..., STOP. Read: START, addr+R, data..., NACK, STOP.
module i2c_mem_target #(
  parameter logic [6:0]  I2C_ADDR = 7'h50,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i2c_scl,
  input  logic              i_i2c_sda,
  output logic              o_i2c_sda,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  state_t            state;
  logic              scl_s1, scl_s2, scl_h;
  logic              sda_s1, sda_s2, sda_h;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [MEM_AW-1:0] ptr;
  logic              rw;
  logic              mack;
  logic              load_pend;

  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Two-flop synchronizers plus one history flop per line; idle bus reads high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {scl_s1, scl_s2, scl_h} <= '1;
      {sda_s1, sda_s2, sda_h} <= '1;
    end else begin
      scl_s1 <= i_i2c_scl;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= i_i2c_sda;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // Bus events derived from the synchronized level and its history.
  always_comb begin
    scl_rise = scl_s2 & ~scl_h;
    scl_fall = ~scl_s2 & scl_h;
    start_ev = scl_s2 & scl_h & ~sda_s2 & sda_h;
    stop_ev  = scl_s2 & scl_h & sda_s2 & ~sda_h;
  end

  // Protocol FSM with registered SDA drive and memory strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_i2c_sda   <= 1'b1;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
      ptr         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      mack        <= 1'b0;
      load_pend   <= 1'b0;
    end else begin
      o_mem_we  <= 1'b0;
      o_mem_re  <= 1'b0;
      // Read data is valid one edge after the strobe was seen by the memory.
      load_pend <= o_mem_re;
      if (load_pend) shreg <= i_mem_rdata;

      if (start_ev) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        o_i2c_sda <= 1'b1;
        mack      <= 1'b0;
      end else if (stop_ev) begin
        state     <= IDLE;
        o_i2c_sda <= 1'b1;
        o_busy    <= 1'b0;
        mack      <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (shreg[7:1] == I2C_ADDR) begin
                  o_i2c_sda <= 1'b0;
                  o_busy    <= 1'b1;
                  rw        <= shreg[0];
                  state     <= ADDR_ACK;
                end else begin
                  o_busy <= 1'b0;
                  state  <= IGNORE;
                end
              end else if (state == PTR) begin
                ptr       <= shreg[MEM_AW-1:0];
                o_i2c_sda <= 1'b0;
                state     <= PTR_ACK;
              end else begin
                o_mem_wdata <= shreg;
                o_mem_addr  <= ptr;
                o_mem_we    <= 1'b1;
                ptr         <= ptr + MEM_AW'(1);
                o_i2c_sda   <= 1'b0;
                state       <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (rw) begin
              if (scl_rise) begin
                o_mem_re   <= 1'b1;
                o_mem_addr <= ptr;
              end else if (scl_fall) begin
                o_i2c_sda <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
                bit_cnt   <= 4'd1;
                state     <= RDATA;
              end
            end else if (scl_fall) begin
              o_i2c_sda <= 1'b1;
              bit_cnt   <= '0;
              state     <= PTR;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              o_i2c_sda <= 1'b1;
              bit_cnt   <= '0;
              state     <= WDATA;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                o_i2c_sda <= 1'b1;
                ptr       <= ptr + MEM_AW'(1);
                state     <= RD_MACK;
              end else begin
                o_i2c_sda <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                mack       <= 1'b1;
                o_mem_re   <= 1'b1;
                o_mem_addr <= ptr;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && mack) begin
              mack      <= 1'b0;
              o_i2c_sda <= shreg[7];
              shreg     <= {shreg[6:0], 1'b0};
              bit_cnt   <= 4'd1;
              state     <= RDATA;
            end
          end
          IDLE, IGNORE: o_i2c_sda <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_target.sv
// Bench for i2c_mem_target: bit-banged I2C controller, memory model and strobe scoreboard.
module tb_i2c_mem_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       dut_sda;
  logic       sda_bus;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  logic [7:0] mem [256];

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned sda_low_cnt = 0;

  assign sda_bus = m_sda & dut_sda;

  always #5 clk = ~clk;

  i2c_mem_target #(.I2C_ADDR(7'h50), .MEM_AW(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_i2c_scl  (m_scl),
    .i_i2c_sda  (sda_bus),
    .o_i2c_sda  (dut_sda),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_we   (mem_we),
    .o_mem_re   (mem_re),
    .i_mem_rdata(mem_rdata),
    .o_busy     (busy)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  // Synchronous SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: every memory access must match the next expected entry.
  always @(negedge clk) begin
    if (!dut_sda) sda_low_cnt++;
    if (mem_we && mem_re) check("we_re_exclusive", 1, 0);
    if (mem_we || mem_re) begin
      ev_t e;
      if (exp_q.size() == 0) begin
        check(mem_we ? "spurious_we" : "spurious_re", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, mem_we}, {31'd0, e.is_wr});
        check("strobe_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        if (mem_we) check("wdata", {24'd0, mem_wdata}, {24'd0, e.data});
      end
    end
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b1; wait_q(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q / 2);
    b = sda_bus;  wait_q(Q / 2);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  function automatic ev_t ev_wr(input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic ev_t ev_rd(input logic [7:0] a);
    ev_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = 8'h00;
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    logic        ack;
    logic [7:0]  d;
    int unsigned low_before;

    rst = 1'b1;
    wait_q(5);
    check("rst_sda",   {31'd0, dut_sda},  1);
    check("rst_we",    {31'd0, mem_we},   0);
    check("rst_re",    {31'd0, mem_re},   0);
    check("rst_addr",  {24'd0, mem_addr}, 0);
    check("rst_wdata", {24'd0, mem_wdata}, 0);
    check("rst_busy",  {31'd0, busy},     0);
    rst = 1'b0;
    wait_q(5);

    // Three-byte write starting at 0x10.
    i2c_start();
    wr_byte(8'hA0, ack); check("wr_addr_ack", {31'd0, ack}, 0);
    check("wr_busy_on", {31'd0, busy}, 1);
    wr_byte(8'h10, ack); check("wr_ptr_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_wr(8'h10, 8'h11));
    wr_byte(8'h11, ack); check("wr_d0_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_wr(8'h11, 8'h22));
    wr_byte(8'h22, ack); check("wr_d1_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_wr(8'h12, 8'h33));
    wr_byte(8'h33, ack); check("wr_d2_ack", {31'd0, ack}, 0);
    check("wr_busy_held", {31'd0, busy}, 1);
    i2c_stop();
    check("wr_busy_off", {31'd0, busy}, 0);

    // Random read through repeated START; a fourth read proves the pointer reached 0x13.
    i2c_start();
    wr_byte(8'hA0, ack); check("rd_addrw_ack", {31'd0, ack}, 0);
    wr_byte(8'h10, ack); check("rd_ptr_ack", {31'd0, ack}, 0);
    i2c_start();
    exp_q.push_back(ev_rd(8'h10));
    wr_byte(8'hA1, ack); check("rd_addrr_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_rd(8'h11));
    rd_byte(1'b0, d); check("rd_byte0", {24'd0, d}, 32'h11);
    exp_q.push_back(ev_rd(8'h12));
    rd_byte(1'b0, d); check("rd_byte1", {24'd0, d}, 32'h22);
    rd_byte(1'b1, d); check("rd_byte2", {24'd0, d}, 32'h33);
    i2c_start();
    exp_q.push_back(ev_rd(8'h13));
    wr_byte(8'hA1, ack); check("rd_ptr13_ack", {31'd0, ack}, 0);
    rd_byte(1'b1, d); check("rd_ptr13_data", {24'd0, d}, 32'h00);
    i2c_stop();

    // Address mismatch: bus never pulled low by the target.
    low_before = sda_low_cnt;
    i2c_start();
    wr_byte(8'hA2, ack); check("nm_addr_nack", {31'd0, ack}, 1);
    check("nm_busy", {31'd0, busy}, 0);
    wr_byte(8'h55, ack); check("nm_data_nack", {31'd0, ack}, 1);
    i2c_stop();
    check("nm_sda_low_cycles", sda_low_cnt - low_before, 0);
    check("nm_busy_after", {31'd0, busy}, 0);

    // Pointer wrap from 0xFF to 0x00.
    i2c_start();
    wr_byte(8'hA0, ack); check("wrap_addr_ack", {31'd0, ack}, 0);
    wr_byte(8'hFF, ack); check("wrap_ptr_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_wr(8'hFF, 8'hAA));
    wr_byte(8'hAA, ack); check("wrap_d0_ack", {31'd0, ack}, 0);
    exp_q.push_back(ev_wr(8'h00, 8'hBB));
    wr_byte(8'hBB, ack); check("wrap_d1_ack", {31'd0, ack}, 0);
    i2c_stop();

    // Abort mid-byte with STOP: nothing written, next transaction still works.
    i2c_start();
    wr_byte(8'hA0, ack); check("ab_addr_ack", {31'd0, ack}, 0);
    wr_byte(8'h20, ack); check("ab_ptr_ack", {31'd0, ack}, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    check("ab_busy_off", {31'd0, busy}, 0);
    i2c_start();
    wr_byte(8'hA0, ack); check("ab_next_addr_ack", {31'd0, ack}, 0);
    wr_byte(8'h30, ack); check("ab_next_ptr_ack", {31'd0, ack}, 0);

    // Reset while the target drives bit 7 (0) of the byte read from 0x30.
    i2c_start();
    exp_q.push_back(ev_rd(8'h30));
    wr_byte(8'hA1, ack); check("rr_addr_ack", {31'd0, ack}, 0);
    check("rr_driving_low", {31'd0, dut_sda}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rr_sda_released", {31'd0, dut_sda}, 1);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_addr", {24'd0, mem_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_q(2);
    i2c_stop();
    i2c_start();
    exp_q.push_back(ev_rd(8'h00));
    wr_byte(8'hA1, ack); check("rr_ptr0_ack", {31'd0, ack}, 0);
    rd_byte(1'b1, d); check("rr_ptr0_data", {24'd0, d}, 32'hBB);
    i2c_stop();
    wait_q(10);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
